// File: rtl/pll_lock_supervisor.sv
// Reset/lock sequencer for a PLL: pulses pll_rst, waits for and qualifies `locked`, then releases sys_rst.
// Optional lost-lock counter is built only when PLL_SUP_LOSS_CNT_EN is defined; otherwise lost_lock_count is 0.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       pll_ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [7:0] retry_count,
  output logic [7:0] lost_lock_count
);

  localparam int MAX_RT  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_ALL = (MAX_RT > LOCK_STABLE_CYCLES) ? MAX_RT : LOCK_STABLE_CYCLES;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             retry_q, retry_d;
  logic [7:0]             retry_inc;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   locked_s;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   pll_ready_q, pll_ready_d;
  logic                   fail_q, fail_d;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], locked};
  assign locked_s = sync_q[SYNC_STAGES-1];

  // State register: FSM, counters, synchronizer and registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      retry_q     <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      pll_ready_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      sync_q      <= sync_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      pll_ready_q <= pll_ready_d;
      fail_q      <= fail_d;
    end
  end

  // Next-state logic; relock_req outranks every other event outside RESET.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    retry_inc = retry_q + 8'd1;
    case (state_q)
      ST_RESET: begin
        if (cnt_q == CW'(RST_PULSE_CYCLES - 1))
          state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (relock_req) begin
          state_d = ST_RESET;
          retry_d = 8'd0;
        end else if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          retry_d = retry_inc;
          state_d = (retry_inc == 8'(MAX_RETRIES)) ? ST_FAIL : ST_RESET;
        end
      end
      ST_STABLE: begin
        if (relock_req) begin
          state_d = ST_RESET;
          retry_d = 8'd0;
        end else if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = ST_RUN;
          retry_d = 8'd0;
        end
      end
      ST_RUN: begin
        if (relock_req) begin
          state_d = ST_RESET;
          retry_d = 8'd0;
        end else if (!locked_s) begin
          state_d = ST_RESET;
        end
      end
      ST_FAIL: begin
        if (relock_req) begin
          state_d = ST_RESET;
          retry_d = 8'd0;
        end
      end
      default: state_d = ST_RESET;
    endcase

    // Counter restarts on every state change and is frozen where nothing is timed.
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q == ST_RESET || state_q == ST_WAIT_LOCK || state_q == ST_STABLE)
      cnt_d = cnt_q + CW'(1);
  end

  // Outputs decoded from the next state so they line up with state_q.
  always_comb begin
    pll_rst_d   = (state_d == ST_RESET) || (state_d == ST_FAIL);
    sys_rst_d   = (state_d != ST_RUN);
    pll_ready_d = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign pll_ready   = pll_ready_q;
  assign fail        = fail_q;
  assign state       = state_q;
  assign retry_count = retry_q;

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [7:0] lost_q, lost_d;
  logic       loss_evt;

  always_comb begin
    loss_evt = (state_q == ST_RUN) && !locked_s && !relock_req;
    lost_d   = lost_q;
    if (loss_evt && (lost_q != 8'hFF))
      lost_d = lost_q + 8'd1;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst)
      lost_q <= '0;
    else
      lost_q <= lost_d;
  end

  assign lost_lock_count = lost_q;
`else
  assign lost_lock_count = 8'd0;
`endif

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Sequences reset and lock qualification for a two-output PLL clock generator, such as the 96/48 MHz from 360 MHz PLL.
- Pulses the PLL reset and waits for `locked` with a timeout.
- Qualifies `locked` as stable for a programmable time, then releases the downstream system reset.
- Retries on timeout and re-sequences on lock loss.
- Runs on the free-running PLL reference clock; its outputs feed the PLL `rst` input and the reset trees of the outclk domains.

Parameters:
- RST_PULSE_CYCLES, 16, pll_rst high time in refclk cycles (>=1).
- LOCK_TIMEOUT_CYCLES, 65536, max cycles in WAIT_LOCK before a retry (>=2).
- LOCK_STABLE_CYCLES, 1024, cycles `locked` must stay high continuously before release (>=1).
- MAX_RETRIES, 3, consecutive timeouts allowed before FAIL (1..255).
- SYNC_STAGES, 2, synchronizer depth for `locked` (>=2).

Ports:
- refclk, input, 1, free-running reference clock; the only clock.
- rst, input, 1, asynchronous active-high reset.
- locked, input, 1, PLL lock indication; asynchronous to refclk.
- relock_req, input, 1, single-cycle request to re-sequence the PLL (sync to refclk).
- pll_rst, output, 1, reset to the PLL, active-high.
- sys_rst, output, 1, downstream reset, active-high.
- pll_ready, output, 1, high only in RUN.
- fail, output, 1, high only in FAIL.
- state, output, 3, current FSM state encoding.
- retry_count, output, 8, consecutive timeouts since the last successful lock.
- lost_lock_count, output, 8, saturating count of lock losses seen in RUN.

Behaviour:
- Clock and reset: one clock, `refclk`. `rst` is asynchronous and active-high.
- Reset values: state=RESET, pll_rst=1, sys_rst=1, pll_ready=0, fail=0, retry_count=0, lost_lock_count=0, all internal counters and synchronizer flops=0.
- Synchronization: `locked` passes through a SYNC_STAGES flop chain to give locked_s. Latency is SYNC_STAGES cycles. All decisions use locked_s only.
- Outputs: all are registered and change on the cycle after the state transition is decided.
- State encoding: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- RESET:
  - pll_rst=1, sys_rst=1.
  - Stays exactly RST_PULSE_CYCLES cycles, counting from entry, then goes to WAIT_LOCK.
  - pll_rst falls on entry to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1. The timeout counter starts at 0 on entry.
  - If locked_s=1, go to STABLE.
  - Else, when the counter reaches LOCK_TIMEOUT_CYCLES-1, increment retry_count:
    - if the new value equals MAX_RETRIES, go to FAIL;
    - otherwise go to RESET.
- STABLE:
  - sys_rst=1. The stable counter starts at 0 on entry.
  - If locked_s=0, go back to WAIT_LOCK with a fresh timeout counter; retry_count is unchanged.
  - When the counter reaches LOCK_STABLE_CYCLES-1 with locked_s still 1, go to RUN and clear retry_count.
- RUN:
  - sys_rst=0, pll_ready=1.
  - If locked_s=0, go to RESET; sys_rst reasserts on the next edge.
  - lost_lock_count increments and saturates at 255; it is never cleared except by rst.
- FAIL:
  - pll_rst=1, sys_rst=1, fail=1.
  - Held until relock_req or rst.
- relock_req:
  - In any state other than RESET, go to RESET and clear retry_count.
  - Ignored in RESET.
  - Takes priority over a timeout, stable-complete or lock-loss event in the same cycle.
- Simultaneous events:
  - Timeout and locked_s rising in the same cycle: lock wins and the FSM goes to STABLE.
  - Stable-complete and locked_s falling in the same cycle: the drop wins and the FSM goes to WAIT_LOCK.
- Reset mid-operation: asserting rst in any state immediately forces all reset values, asynchronously.
- Widths: internal counters are `$clog2` of the largest of RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES and LOCK_STABLE_CYCLES, plus 1. No wrap is possible.

Optional Feature:
- Macro: PLL_SUP_LOSS_CNT_EN.
- Defined: lost_lock_count behaves as above.
- Undefined: the lost_lock_count register is removed and the output is tied to 8'd0. The FSM behaviour is otherwise identical.

Test Plan:
Use RST_PULSE=4, TIMEOUT=32, STABLE=8, MAX_RETRIES=2, SYNC=2 for all scenarios.
1. Normal lock:
   - Stimulus: release rst; raise locked 10 cycles later.
   - Required: pll_rst high for exactly 4 cycles; sys_rst falls 2+8 cycles after the locked rise (±1 for entry); pll_ready=1; state=3.
2. Timeout to FAIL:
   - Stimulus: hold locked=0.
   - Required: two pll_rst pulses, 32 cycles of WAIT_LOCK each; retry_count goes 1 then 2; state=4, fail=1, pll_rst=1.
3. Glitch in STABLE:
   - Stimulus: locked high for 5 cycles, low 1 cycle, then high.
   - Required: FSM returns to WAIT_LOCK, then reaches RUN a full 8 cycles after the second rise; retry_count=0.
4. Lock loss in RUN:
   - Stimulus: drop locked while in RUN.
   - Required: sys_rst=1 within 3 cycles; new 4-cycle pll_rst pulse; lost_lock_count=1 (0 with the macro undefined).
5. Recovery from FAIL:
   - Stimulus: pulse relock_req in FAIL, then raise locked.
   - Required: retry_count=0; full sequence ends in RUN.
6. Async reset:
   - Stimulus: assert rst in STABLE between clock edges.
   - Required: pll_rst=1 and sys_rst=1 before the next edge; state=0.
